// File: rtl/wb_rr_arbiter_if.sv
// Wishbone bundle for the two-master / one-slave round-robin arbiter.
// Signal suffixes (_i/_o) are from the arbiter's point of view.
// The slave modport is the arbiter itself.
// The master modport is the surrounding environment: both requesters plus the shared slave.
interface wb_rr_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16
);
    logic                  m0_cyc_i;
    logic                  m0_stb_i;
    logic                  m0_we_i;
    logic [ADDR_WIDTH-1:0] m0_adr_i;
    logic [DATA_WIDTH-1:0] m0_dat_i;
    logic                  m0_ack_o;
    logic                  m0_err_o;

    logic                  m1_cyc_i;
    logic                  m1_stb_i;
    logic                  m1_we_i;
    logic [ADDR_WIDTH-1:0] m1_adr_i;
    logic [DATA_WIDTH-1:0] m1_dat_i;
    logic                  m1_ack_o;
    logic                  m1_err_o;

    logic [DATA_WIDTH-1:0] m_dat_o;

    logic                  s_cyc_o;
    logic                  s_stb_o;
    logic                  s_we_o;
    logic [ADDR_WIDTH-1:0] s_adr_o;
    logic [DATA_WIDTH-1:0] s_dat_o;
    logic                  s_ack_i;
    logic [DATA_WIDTH-1:0] s_dat_i;

    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
        input  s_ack_i, s_dat_i,
        output m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, m_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
        output s_ack_i, s_dat_i,
        input  m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, m_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Two-master, one-slave Wishbone arbiter.
// Whole cycles (cyc to cyc) are granted with round-robin fairness.
// A strobed access left unacknowledged for TIMEOUT_CYCLES cycles is aborted with a one-cycle err pulse.
// The slave-side outputs depend only on registered state and master inputs, never on s_ack_i.
module wb_rr_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    wb_rr_arbiter_if.slave        bus,
    output logic [1:0]            grant_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_grant;
    logic [1:0]       w_grant_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_err_first;
    logic             w_err_first_nxt;

    logic                  w_own;
    logic                  w_own_cyc;
    logic                  w_oth_cyc;
    logic                  w_own_stb;
    logic                  w_own_we;
    logic [ADDR_WIDTH-1:0] w_own_adr;
    logic [DATA_WIDTH-1:0] w_own_dat;
    logic                  w_busy;
    logic                  w_stb;
    logic                  w_ack;
    logic                  w_err;
    logic                  w_limit;
    logic                  w_idle_pick;
    logic [1:0]            w_rel_grant;
    state_t                w_rel_state;

    // Owner index is grant bit 1: 0 selects m0 (also while idle, where everything is gated off).
    assign w_own     = r_grant[1];
    assign w_own_cyc = w_own ? bus.m1_cyc_i : bus.m0_cyc_i;
    assign w_oth_cyc = w_own ? bus.m0_cyc_i : bus.m1_cyc_i;
    assign w_own_stb = w_own ? bus.m1_stb_i : bus.m0_stb_i;
    assign w_own_we  = w_own ? bus.m1_we_i  : bus.m0_we_i;
    assign w_own_adr = w_own ? bus.m1_adr_i : bus.m0_adr_i;
    assign w_own_dat = w_own ? bus.m1_dat_i : bus.m0_dat_i;

    // s_cyc_o stays high through the release cycle.
    // stb is gated by the owner's cyc, so a dropped cycle never strobes.
    assign w_busy      = (r_state == ST_BUSY);
    assign w_stb       = w_busy & w_own_cyc & w_own_stb;
    assign w_ack       = bus.s_ack_i & w_stb;
    assign w_err       = (r_state == ST_ERR) & r_err_first;
    assign w_limit     = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

    assign bus.s_cyc_o  = w_busy;
    assign bus.s_stb_o  = w_stb;
    assign bus.s_we_o   = w_busy & w_own_we;
    assign bus.s_adr_o  = w_busy ? w_own_adr : '0;
    assign bus.s_dat_o  = w_busy ? w_own_dat : '0;
    assign bus.m0_ack_o = w_ack & ~w_own;
    assign bus.m1_ack_o = w_ack &  w_own;
    assign bus.m0_err_o = w_err & ~w_own;
    assign bus.m1_err_o = w_err &  w_own;
    assign bus.m_dat_o  = bus.s_dat_i;
    assign grant_o      = r_grant;

    // On a tie the master that did not win last time gets the bus.
    // A lone requester selects itself.
    assign w_idle_pick = (bus.m0_cyc_i & bus.m1_cyc_i) ? ~r_last : bus.m1_cyc_i;

    // On release, hand straight over to a waiting master, otherwise fall back to idle.
    assign w_rel_grant = w_oth_cyc ? (w_own ? 2'b01 : 2'b10) : 2'b00;
    assign w_rel_state = w_oth_cyc ? ST_BUSY : ST_IDLE;

    // Next-state logic: grant, release/handover and timeout supervision.
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_last_nxt      = r_last;
        w_cnt_nxt       = r_cnt;
        w_err_first_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.m0_cyc_i | bus.m1_cyc_i) begin
                    w_grant_nxt = w_idle_pick ? 2'b10 : 2'b01;
                    w_last_nxt  = w_idle_pick;
                    w_state_nxt = ST_BUSY;
                    w_cnt_nxt   = '0;
                end
            end
            ST_BUSY: begin
                if (!w_own_cyc) begin
                    w_state_nxt = w_rel_state;
                    w_grant_nxt = w_rel_grant;
                    w_last_nxt  = w_oth_cyc ? ~w_own : r_last;
                    w_cnt_nxt   = '0;
                end else if (w_ack) begin
                    w_cnt_nxt = '0;
                end else if (w_stb) begin
                    if (w_limit) begin
                        w_state_nxt     = ST_ERR;
                        w_cnt_nxt       = '0;
                        w_err_first_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            ST_ERR: begin
                if (!w_own_cyc) begin
                    w_state_nxt = w_rel_state;
                    w_grant_nxt = w_rel_grant;
                    w_last_nxt  = w_oth_cyc ? ~w_own : r_last;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 2'b00;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State registers.
    // last_grant resets to m1 so that m0 wins the first tie.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= ST_IDLE;
            r_grant     <= 2'b00;
            r_last      <= 1'b1;
            r_cnt       <= '0;
            r_err_first <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_last      <= w_last_nxt;
            r_cnt       <= w_cnt_nxt;
            r_err_first <= w_err_first_nxt;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (TIMEOUT_CYCLES = 8).
// Inputs change on the falling clock edge, and outputs are sampled there or 1 ns later.
module tb_wb_rr_arbiter;

    logic       clk_i;
    logic       rst_i;
    logic [1:0] grant_o;

    int n_total;
    int n_bad;
    int rem [2];
    int own;

    wb_rr_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(16)) bus ();

    wb_rr_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (16),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .bus    (bus),
        .grant_o(grant_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic req(input int idx, input logic we, input logic [31:0] adr, input logic [15:0] dat);
        if (idx == 0) begin
            bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m0_we_i = we;
            bus.m0_adr_i = adr;  bus.m0_dat_i = dat;
        end else begin
            bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1; bus.m1_we_i = we;
            bus.m1_adr_i = adr;  bus.m1_dat_i = dat;
        end
    endtask

    task automatic drop(input int idx);
        if (idx == 0) begin
            bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0; bus.m0_we_i = 1'b0;
        end else begin
            bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0; bus.m1_we_i = 1'b0;
        end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_i   = 1'b0;
        bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0; bus.m0_we_i = 1'b0;
        bus.m0_adr_i = '0;   bus.m0_dat_i = '0;
        bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0; bus.m1_we_i = 1'b0;
        bus.m1_adr_i = '0;   bus.m1_dat_i = '0;
        bus.s_ack_i  = 1'b0; bus.s_dat_i  = '0;

        // Reset state
        tick; tick;
        check("rst_grant", grant_o, 2'b00);
        check("rst_scyc", bus.s_cyc_o, 1'b0);
        check("rst_sstb", bus.s_stb_o, 1'b0);
        check("rst_acks", {bus.m0_ack_o, bus.m1_ack_o, bus.m0_err_o, bus.m1_err_o}, 4'b0000);
        rst_i = 1'b1;

        // Single master write with a 3-cycle slave
        tick;
        req(0, 1'b1, 32'h2, 16'h00C0);
        #1 check("single_scyc_not_yet", bus.s_cyc_o, 1'b0);
        tick;
        check("single_grant", grant_o, 2'b01);
        check("single_scyc", bus.s_cyc_o, 1'b1);
        check("single_adr", bus.s_adr_o, 32'h2);
        check("single_dat", bus.s_dat_o, 16'h00C0);
        check("single_we", bus.s_we_o, 1'b1);
        check("single_noack0", bus.m0_ack_o, 1'b0);
        tick;
        check("single_noack1", bus.m0_ack_o, 1'b0);
        tick;
        bus.s_ack_i = 1'b1;
        #1 check("single_ack", bus.m0_ack_o, 1'b1);
        check("single_m1_noack", bus.m1_ack_o, 1'b0);
        tick;
        bus.s_ack_i = 1'b0;
        drop(0);
        #1 check("single_ack_done", bus.m0_ack_o, 1'b0);
        check("single_rel_scyc", bus.s_cyc_o, 1'b1);
        check("single_rel_sstb", bus.s_stb_o, 1'b0);
        tick;
        check("single_idle_grant", grant_o, 2'b00);
        check("single_idle_scyc", bus.s_cyc_o, 1'b0);

        // Contention right after reset: m0 first, direct handover to m1
        rst_i = 1'b0;
        #2 rst_i = 1'b1;
        tick;
        req(0, 1'b1, 32'h10, 16'h1111);
        req(1, 1'b0, 32'h20, 16'h0000);
        tick;
        check("cont_grant_m0", grant_o, 2'b01);
        check("cont_adr_m0", bus.s_adr_o, 32'h10);
        bus.s_ack_i = 1'b1;
        #1 check("cont_m0_ack", bus.m0_ack_o, 1'b1);
        check("cont_m1_noack", bus.m1_ack_o, 1'b0);
        tick;
        bus.s_ack_i = 1'b0;
        drop(0);
        #1 check("cont_rel_grant", grant_o, 2'b01);
        tick;
        check("cont_grant_m1", grant_o, 2'b10);
        check("cont_adr_m1", bus.s_adr_o, 32'h20);
        check("cont_we_m1", bus.s_we_o, 1'b0);
        bus.s_dat_i = 16'h0055;
        bus.s_ack_i = 1'b1;
        #1 check("cont_m1_ack", bus.m1_ack_o, 1'b1);
        check("cont_mdat", bus.m_dat_o, 16'h0055);
        check("cont_m0_stays0", bus.m0_ack_o, 1'b0);
        tick;
        bus.s_ack_i = 1'b0;
        drop(1);
        tick;
        check("cont_idle", grant_o, 2'b00);

        // Fairness: four requests each, grants alternate starting with m0
        rem[0] = 4;
        rem[1] = 4;
        req(0, 1'b1, 32'h100, 16'h0A0A);
        req(1, 1'b1, 32'h200, 16'h0B0B);
        for (int k = 0; k < 8; k++) begin
            own = k % 2;
            tick;
            check($sformatf("fair_grant%0d", k), grant_o, (own == 1) ? 2'b10 : 2'b01);
            if (k > 0 && rem[1 - own] > 0)
                req(1 - own, 1'b1, (own == 1) ? 32'h100 : 32'h200, 16'h0C0C);
            bus.s_ack_i = 1'b1;
            #1 check($sformatf("fair_ack%0d", k), (own == 1) ? bus.m1_ack_o : bus.m0_ack_o, 1'b1);
            tick;
            bus.s_ack_i = 1'b0;
            drop(own);
            rem[own] = rem[own] - 1;
        end
        tick;
        check("fair_idle", grant_o, 2'b00);

        // Bus lock: m1 keeps the grant for 3 beats while m0 waits
        req(1, 1'b0, 32'h300, 16'h0000);
        tick;
        check("lock_grant_m1", grant_o, 2'b10);
        req(0, 1'b1, 32'h40, 16'h4444);
        for (int b = 0; b < 3; b++) begin
            bus.s_dat_i = 16'h0100 + 16'(b);
            bus.s_ack_i = 1'b1;
            #1 check($sformatf("lock_m1_ack%0d", b), bus.m1_ack_o, 1'b1);
            check($sformatf("lock_m0_noack%0d", b), bus.m0_ack_o, 1'b0);
            check($sformatf("lock_mdat%0d", b), bus.m_dat_o, 16'h0100 + 16'(b));
            tick;
            bus.s_ack_i = 1'b0;
            check($sformatf("lock_hold%0d", b), grant_o, 2'b10);
            tick;
        end
        drop(1);
        tick;
        check("lock_grant_m0", grant_o, 2'b01);
        check("lock_adr_m0", bus.s_adr_o, 32'h40);
        bus.s_ack_i = 1'b1;
        #1 check("lock_m0_ack", bus.m0_ack_o, 1'b1);
        tick;
        bus.s_ack_i = 1'b0;
        drop(0);
        tick;
        check("lock_idle", grant_o, 2'b00);

        // Timeout: slave never answers
        req(0, 1'b0, 32'h8, 16'h0808);
        for (int i = 0; i < 8; i++) begin
            tick;
            check($sformatf("to_stb%0d", i), bus.s_stb_o, 1'b1);
            check($sformatf("to_noerr%0d", i), bus.m0_err_o, 1'b0);
        end
        tick;
        check("to_err_pulse", bus.m0_err_o, 1'b1);
        check("to_m1_noerr", bus.m1_err_o, 1'b0);
        check("to_scyc_low", bus.s_cyc_o, 1'b0);
        check("to_sstb_low", bus.s_stb_o, 1'b0);
        bus.s_ack_i = 1'b1;
        #1 check("to_late_ack", bus.m0_ack_o, 1'b0);
        tick;
        check("to_err_once", bus.m0_err_o, 1'b0);
        check("to_late_ack2", bus.m0_ack_o, 1'b0);
        check("to_err_hold", grant_o, 2'b01);
        bus.s_ack_i = 1'b0;
        drop(0);
        tick;
        check("to_idle", grant_o, 2'b00);

        // Timeout boundary: ack arrives on the 8th strobed cycle
        req(0, 1'b0, 32'h9, 16'h0909);
        for (int i = 0; i < 7; i++) begin
            tick;
            check($sformatf("tb_stb%0d", i), bus.s_stb_o, 1'b1);
        end
        tick;
        check("tb_stb7", bus.s_stb_o, 1'b1);
        bus.s_ack_i = 1'b1;
        #1 check("tb_ack8", bus.m0_ack_o, 1'b1);
        tick;
        bus.s_ack_i = 1'b0;
        check("tb_noerr", bus.m0_err_o, 1'b0);
        check("tb_still_busy", bus.s_cyc_o, 1'b1);
        drop(0);
        tick;
        check("tb_idle", grant_o, 2'b00);
        check("tb_noerr2", bus.m0_err_o, 1'b0);

        // Reset in the middle of a pending write
        req(0, 1'b1, 32'h33, 16'hBEEF);
        tick;
        check("mid_scyc", bus.s_cyc_o, 1'b1);
        check("mid_adr", bus.s_adr_o, 32'h33);
        bus.s_ack_i = 1'b1;
        #2 rst_i = 1'b0;
        #1;
        check("mid_rst_scyc", bus.s_cyc_o, 1'b0);
        check("mid_rst_sstb", bus.s_stb_o, 1'b0);
        check("mid_rst_swe", bus.s_we_o, 1'b0);
        check("mid_rst_adr", bus.s_adr_o, 32'h0);
        check("mid_rst_dat", bus.s_dat_o, 16'h0);
        check("mid_rst_grant", grant_o, 2'b00);
        check("mid_rst_ackerr", {bus.m0_ack_o, bus.m0_err_o}, 2'b00);
        bus.s_ack_i = 1'b0;
        req(1, 1'b0, 32'h44, 16'h0000);
        tick;
        rst_i = 1'b1;
        tick;
        check("mid_tie_m0", grant_o, 2'b01);
        drop(0);
        drop(1);
        tick;
        tick;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
